// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - lookup, update and statistics signals of branch_predictor
interface branch_predictor_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] lk_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [PC_W-1:0] pred_next_pc;
  logic            ready;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_branch;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic [31:0]     stat_lookups;
  logic [31:0]     stat_hits;

  modport master (
    output lk_pc, upd_valid, upd_pc, upd_branch, upd_taken, upd_target,
    input  pred_hit, pred_taken, pred_next_pc, ready, stat_lookups, stat_hits
  );

  modport slave (
    input  lk_pc, upd_valid, upd_pc, upd_branch, upd_taken, upd_target,
    output pred_hit, pred_taken, pred_next_pc, ready, stat_lookups, stat_hits
  );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - tagged BTB with saturating direction counters
// Registered IF-stage lookup, read-modify-write training from WB, clear sweep after reset.
module branch_predictor #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 10,
  parameter int TAG_W = 8,
  parameter int CNT_W = 2
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic              ready_q;
  logic              hit_q;
  logic              taken_q;
  logic [PC_W-1:0]   next_q;
  logic [31:0]       lookups_q;
  logic [31:0]       hits_q;

  logic [DEPTH-1:0]  tbl_valid;
  logic [TAG_W-1:0]  tbl_tag [DEPTH];
  logic [CNT_W-1:0]  tbl_cnt [DEPTH];
  logic [PC_W-3:0]   tbl_tgt [DEPTH];

  // Pending write: the full entry computed at the previous update edge
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_valid;
  logic [TAG_W-1:0]  wr_tag;
  logic [CNT_W-1:0]  wr_cnt;
  logic [PC_W-3:0]   wr_tgt;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic              lk_taken;
  logic [PC_W-1:0]   lk_seq;

  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              byp;
  logic              e_valid;
  logic [TAG_W-1:0]  e_tag;
  logic [CNT_W-1:0]  e_cnt;
  logic [PC_W-3:0]   e_tgt;
  logic              upd_hit;

  logic              n_we;
  logic              n_valid;
  logic [TAG_W-1:0]  n_tag;
  logic [CNT_W-1:0]  n_cnt;
  logic [PC_W-3:0]   n_tgt;

  logic              unused_bits;

  assign unused_bits = ^{bp.upd_pc, bp.upd_target[1:0]};

  assign lk_idx   = bp.lk_pc[2 +: IDX_W];
  assign lk_tag   = bp.lk_pc[2 + IDX_W +: TAG_W];
  assign lk_hit   = tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && tbl_cnt[lk_idx][CNT_W-1];
  assign lk_seq   = bp.lk_pc + PC_W'(4);

  // Back-to-back updates to one index read the not-yet-written entry
  assign upd_idx = bp.upd_pc[2 +: IDX_W];
  assign upd_tag = bp.upd_pc[2 + IDX_W +: TAG_W];
  assign byp     = wr_en && (wr_idx == upd_idx);
  assign e_valid = byp ? wr_valid : tbl_valid[upd_idx];
  assign e_tag   = byp ? wr_tag   : tbl_tag[upd_idx];
  assign e_cnt   = byp ? wr_cnt   : tbl_cnt[upd_idx];
  assign e_tgt   = byp ? wr_tgt   : tbl_tgt[upd_idx];
  assign upd_hit = e_valid && (e_tag == upd_tag);

  always_comb begin
    n_we    = 1'b0;
    n_valid = e_valid;
    n_tag   = e_tag;
    n_cnt   = e_cnt;
    n_tgt   = e_tgt;
    if (upd_hit) begin
      n_we = 1'b1;
      if (!bp.upd_branch) begin
        n_valid = 1'b0;
      end else if (bp.upd_taken) begin
        n_cnt = (e_cnt == CNT_MAX) ? e_cnt : e_cnt + CNT_W'(1);
        n_tgt = bp.upd_target[PC_W-1:2];
      end else begin
        n_cnt = (e_cnt == '0) ? e_cnt : e_cnt - CNT_W'(1);
      end
    end else if (bp.upd_branch && bp.upd_taken) begin
      n_we    = 1'b1;
      n_valid = 1'b1;
      n_tag   = upd_tag;
      n_cnt   = CNT_WEAK;
      n_tgt   = bp.upd_target[PC_W-1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      ptr       <= '0;
      ready_q   <= 1'b0;
      hit_q     <= 1'b0;
      taken_q   <= 1'b0;
      next_q    <= '0;
      lookups_q <= '0;
      hits_q    <= '0;
      wr_en     <= 1'b0;
      wr_idx    <= '0;
      wr_valid  <= 1'b0;
      wr_tag    <= '0;
      wr_cnt    <= '0;
      wr_tgt    <= '0;
    end else if (state == CLEAR) begin
      ptr     <= ptr + IDX_W'(1);
      hit_q   <= 1'b0;
      taken_q <= 1'b0;
      next_q  <= lk_seq;
      wr_en   <= 1'b0;
      if (&ptr) begin
        state   <= RUN;
        ready_q <= 1'b1;
      end
    end else begin
      hit_q   <= lk_hit;
      taken_q <= lk_taken;
      next_q  <= lk_taken ? {tbl_tgt[lk_idx], 2'b00} : lk_seq;
      if (lookups_q != '1) lookups_q <= lookups_q + 32'd1;
      if (lk_taken && hits_q != '1) hits_q <= hits_q + 32'd1;
      wr_en    <= bp.upd_valid && n_we;
      wr_idx   <= upd_idx;
      wr_valid <= n_valid;
      wr_tag   <= n_tag;
      wr_cnt   <= n_cnt;
      wr_tgt   <= n_tgt;
    end
  end

  // Table writes land after this edge's lookup read, giving read-before-write
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        tbl_valid[ptr] <= 1'b0;
      end else if (wr_en) begin
        tbl_valid[wr_idx] <= wr_valid;
        tbl_tag[wr_idx]   <= wr_tag;
        tbl_cnt[wr_idx]   <= wr_cnt;
        tbl_tgt[wr_idx]   <= wr_tgt;
      end
    end
  end

  assign bp.pred_hit     = hit_q;
  assign bp.pred_taken   = taken_q;
  assign bp.pred_next_pc = next_q;
  assign bp.ready        = ready_q;
  assign bp.stat_lookups = lookups_q;
  assign bp.stat_hits    = hits_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and random checks of branch_predictor against a table model
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;

  branch_predictor_if #(.PC_W(32)) bp ();

  branch_predictor #(.PC_W(32), .IDX_W(4), .TAG_W(4), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit          m_valid [16];
  int          m_tagv  [16];
  int          m_cnt   [16];
  logic [31:0] m_tgt   [16];
  bit          running;
  int          since;
  int          e_lk, e_hits;
  bit          e_hit, e_taken;
  logic [31:0] e_next;
  bit          pend_v, pend_b, pend_t;
  logic [31:0] pend_pc, pend_tgt;

  function automatic int f_idx(logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic int f_tag(logic [31:0] pc);
    return int'((pc >> 6) % 16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_update(input logic [31:0] pc, input bit b, input bit t, input logic [31:0] tg);
    int i;
    bit hit;
    i = f_idx(pc);
    hit = m_valid[i] && m_tagv[i] == f_tag(pc);
    if (hit) begin
      if (!b) m_valid[i] = 0;
      else if (t) begin
        m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
        m_tgt[i] = tg & ~32'd3;
      end else m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
    end else if (b && t) begin
      m_valid[i] = 1;
      m_tagv[i]  = f_tag(pc);
      m_cnt[i]   = 2;
      m_tgt[i]   = tg & ~32'd3;
    end
  endtask

  task automatic step(input bit r, input logic [31:0] lk, input bit uv, input logic [31:0] upc,
                      input bit ub, input bit ut, input logic [31:0] utg);
    int i;
    rst = r;
    bp.lk_pc = lk; bp.upd_valid = uv; bp.upd_pc = upc;
    bp.upd_branch = ub; bp.upd_taken = ut; bp.upd_target = utg;
    @(posedge clk);
    if (r) begin
      running = 0; since = 0; pend_v = 0; e_lk = 0; e_hits = 0;
      e_hit = 0; e_taken = 0; e_next = 32'd0;
      for (int k = 0; k < 16; k++) m_valid[k] = 0;
    end else if (!running) begin
      e_hit = 0; e_taken = 0; e_next = lk + 32'd4;
      since++;
      if (since == 16) running = 1;
    end else begin
      i = f_idx(lk);
      e_hit   = m_valid[i] && m_tagv[i] == f_tag(lk);
      e_taken = e_hit && m_cnt[i] >= 2;
      e_next  = e_taken ? m_tgt[i] : lk + 32'd4;
      e_lk++;
      if (e_taken) e_hits++;
      // An update becomes visible to the lookup two edges after it was presented
      if (pend_v) apply_update(pend_pc, pend_b, pend_t, pend_tgt);
      pend_v = uv; pend_pc = upc; pend_b = ub; pend_t = ut; pend_tgt = utg;
    end
    #1;
    chk("ready", 32'(bp.ready), 32'(running));
    chk("pred_hit", 32'(bp.pred_hit), 32'(e_hit));
    chk("pred_taken", 32'(bp.pred_taken), 32'(e_taken));
    chk("pred_next_pc", bp.pred_next_pc, e_next);
    chk("stat_lookups", bp.stat_lookups, 32'(e_lk));
    chk("stat_hits", bp.stat_hits, 32'(e_hits));
  endtask

  task automatic idle(input logic [31:0] lk);
    step(0, lk, 0, 32'd0, 0, 0, 32'd0);
  endtask

  task automatic upd(input logic [31:0] pc, input bit b, input bit t, input logic [31:0] tg);
    step(0, 32'd0, 1, pc, b, t, tg);
  endtask

  initial begin
    int n;
    logic [31:0] pc, lk;

    // T1: reset, sweep length, first lookups, +4 wrap
    step(1, 32'h40, 0, 32'd0, 0, 0, 32'd0);
    n = 0;
    while (!bp.ready && n < 40) begin
      idle(32'h40);
      n++;
    end
    chk("t1_ready_cycles", 32'(n), 32'd16);
    idle(32'h40);
    chk("t1_hit", 32'(bp.pred_hit), 32'd0);
    chk("t1_next", bp.pred_next_pc, 32'h44);
    idle(32'hFFFF_FFFE);
    chk("t1_wrap", bp.pred_next_pc, 32'h0000_0002);

    // T2: allocate, then lookup two cycles later
    upd(32'h40, 1, 1, 32'h100);
    idle(32'h40);
    idle(32'h40);
    chk("t2_hit", 32'(bp.pred_hit), 32'd1);
    chk("t2_taken", 32'(bp.pred_taken), 32'd1);
    chk("t2_next", bp.pred_next_pc, 32'h100);

    // T3: back-to-back not-taken, then saturation at the top
    upd(32'h40, 1, 0, 32'h0);
    upd(32'h40, 1, 0, 32'h0);
    idle(32'h40);
    idle(32'h40);
    chk("t3_hit", 32'(bp.pred_hit), 32'd1);
    chk("t3_taken", 32'(bp.pred_taken), 32'd0);
    chk("t3_next", bp.pred_next_pc, 32'h44);
    for (int k = 0; k < 4; k++) upd(32'h40, 1, 1, 32'h100);
    upd(32'h40, 1, 0, 32'h0);
    idle(32'h40);
    idle(32'h40);
    chk("t3_sat_taken", 32'(bp.pred_taken), 32'd1);
    chk("t3_sat_next", bp.pred_next_pc, 32'h100);

    // T4: 0x140 shares index 0 with 0x40 but carries tag 5
    idle(32'h140);
    chk("t4_alias_hit", 32'(bp.pred_hit), 32'd0);
    chk("t4_alias_next", bp.pred_next_pc, 32'h144);
    upd(32'h140, 1, 1, 32'h200);
    idle(32'h40);
    idle(32'h40);
    chk("t4_old_hit", 32'(bp.pred_hit), 32'd0);
    idle(32'h140);
    chk("t4_new_next", bp.pred_next_pc, 32'h200);

    // T5: allocate then invalidate on the very next cycle
    upd(32'h40, 1, 1, 32'h100);
    upd(32'h40, 0, 0, 32'h0);
    idle(32'h40);
    idle(32'h40);
    chk("t5_hit", 32'(bp.pred_hit), 32'd0);

    // T6: reset mid-sweep with updates pulsed during the sweep
    upd(32'h40, 1, 1, 32'h100);
    idle(32'h40);
    idle(32'h40);
    chk("t6_pre_hit", 32'(bp.pred_hit), 32'd1);
    step(1, 32'h40, 0, 32'd0, 0, 0, 32'd0);
    for (int k = 0; k < 4; k++) idle(32'h40);
    step(1, 32'h40, 0, 32'd0, 0, 0, 32'd0);
    n = 0;
    while (!bp.ready && n < 40) begin
      step(0, 32'h40, (n % 3) == 0, 32'h40, 1, 1, 32'h300);
      n++;
    end
    chk("t6_ready_cycles", 32'(n), 32'd16);
    idle(32'h40);
    chk("t6_hit_40", 32'(bp.pred_hit), 32'd0);
    idle(32'h140);
    chk("t6_hit_140", 32'(bp.pred_hit), 32'd0);

    // Random traffic over a small PC pool so hits, aliases and bypasses are frequent
    for (int k = 0; k < 500; k++) begin
      pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) pc = pc | ($urandom & 32'hFFFF_FC00);
      lk = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 1) == 0) lk = pc;
      step(0, lk, 1'($urandom_range(0, 1)), pc, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
